// File: rtl/cpu_pkg.sv
// Shared CPU memory-system constants: RAM geometry and arbiter port indices.
package cpu_pkg;

  localparam int unsigned RAM_ADDR_W = 12;
  localparam int unsigned WORD_W     = 32;

  localparam int unsigned PORT_DATA  = 0;
  localparam int unsigned PORT_FETCH = 1;
  localparam int unsigned PORT_HOST  = 2;

endpackage : cpu_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan ptr, ptr+1, ... mod N and take the first asserted request.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IDX_W'((32'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded lock for the single-port synchronous-read RAM.
// Owns the RAM command register and routes read returns back to the issuing port.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned ADDR_W   = RAM_ADDR_W,
  parameter int unsigned DATA_W   = WORD_W,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ-1:0]        we,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata
);

  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned LOCK_W = 8;

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  tag_q, tag_d;
  logic [IDX_W-1:0]  pick_idx;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [N_REQ-1:0]  pick_gnt;
  logic [N_REQ-1:0]  rvalid_d;
  logic              hs;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign gnt   = rst ? '0 : pick_gnt;
  assign hs    = |(req & gnt);
  assign rdata = mem_rdata;

  // Next-state: pointer/lock policy, one-cycle command pulse, read-return routing.
  always_comb begin
    ptr_d       = ptr_q;
    lock_cnt_d  = '0;
    tag_d       = tag_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rvalid_d    = '0;

    if (mem_en && !mem_we) begin
      rvalid_d[tag_q] = 1'b1;
    end

    if (hs) begin
      mem_en_d    = 1'b1;
      mem_we_d    = we[pick_idx];
      mem_addr_d  = addr[32'(pick_idx) * ADDR_W +: ADDR_W];
      mem_wdata_d = wdata[32'(pick_idx) * DATA_W +: DATA_W];
      tag_d       = pick_idx;
      if (lock[pick_idx] && (lock_cnt_q < LOCK_W'(MAX_LOCK - 1))) begin
        ptr_d      = pick_idx;
        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      end else if (pick_idx == IDX_W'(N_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = pick_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      lock_cnt_q <= '0;
      tag_q      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rvalid     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
      tag_q      <= tag_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      rvalid     <= rvalid_d;
    end
  end

endmodule : mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port arbiter for the CPU's 4096×32 word RAM. Shares the RAM between the load/store datapath, instruction fetch and a host loader port. Uses round-robin grants with an optional bounded lock for bursts. Sits between the CPU requesters and the synchronous-read RAM macro and owns every RAM control signal.

## Interface
Parameters:
- N_REQ, 3, number of requesters; port 0 = data (load/store), 1 = fetch, 2 = host.
- ADDR_W, 12, word address width (4096 words).
- DATA_W, 32, word width.
- MAX_LOCK, 8, maximum consecutive locked grants to one port; range 1–255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-port request; held until granted.
- lock  in  N_REQ  per-port priority-hold request; sampled only with req.
- we  in  N_REQ  per-port write enable; 0 = read.
- addr  in  N_REQ*ADDR_W  packed per-port word address; port p at [p*ADDR_W +: ADDR_W].
- wdata  in  N_REQ*DATA_W  packed per-port write data.
- gnt  out  N_REQ  one-hot accept; a transfer occurs on an edge where req[p]&gnt[p].
- rvalid  out  N_REQ  one-hot; read data for port p valid this cycle.
- rdata  out  DATA_W  shared read data bus; qualified by rvalid.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid the cycle after mem_en&~mem_we.

## Operation
- **Request rules.** Each port raises req with stable we/addr/wdata. It must hold them unchanged until the handshake edge. Dropping req before the grant is permitted and cancels the request.
- **Arbitration.** gnt is combinational from req and a registered pointer ptr. Priority order is ptr, ptr+1, … mod N_REQ. At most one gnt bit is high per cycle. gnt is forced 0 while rst is high.
- **Pointer update** on a handshake with port p:
  - If lock[p]=1 and lock_cnt < MAX_LOCK-1: ptr stays at p and lock_cnt increments.
  - Otherwise: ptr becomes (p+1) mod N_REQ and lock_cnt clears.
  - With no handshake, ptr holds and lock_cnt clears.
- **Command register.** On a handshake, mem_en=1 and mem_we/mem_addr/mem_wdata take the granted port's values for exactly one cycle. Otherwise mem_en=0 and mem_we=0; mem_addr and mem_wdata hold.
- **Read return.** For each issued read, a registered tag records the port index. In the cycle after mem_en&~mem_we, rvalid[tag]=1. rdata passes mem_rdata straight through.
- **Writes** produce no rvalid.
- **Throughput.** One handshake per cycle, fully pipelined. Back-to-back grants to the same or different ports are legal.
- **Reset values.** ptr=0, lock_cnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rvalid=0, read tag invalid.
- **Reset mid-operation.** Commands and reads in flight are discarded; no rvalid is asserted after rst.

## Timing
- Handshake on the edge ending cycle t.
- mem_en asserted in cycle t+1.
- rvalid and rdata in cycle t+2. Read latency is 2 cycles from the handshake edge.
- A write commits to the RAM on the edge ending t+1.
- Read-after-write to the same address: a write handshaken at t and a read handshaken at t+1 return the new data. The RAM is write-first, and commands are issued in handshake order.
- **Fairness.** Each continuously requesting port is granted within N_REQ-1+(N_REQ-1)*(MAX_LOCK-1) cycles.
- **Simultaneous requests.** The requesting port nearest ptr, in increasing index order, wins.
- **Lock with req low.** lock has no effect without req.
- **Pointer wrap-around.** Port N_REQ-1 wraps to port 0.

## Structure
- **Shared package** cpu_pkg holds:
  - RAM_ADDR_W=12 and WORD_W=32.
  - Port index constants PORT_DATA=0, PORT_FETCH=1, PORT_HOST=2.
- **Sub-module** rr_pick: combinational round-robin picker with inputs req[N] and ptr, output one-hot gnt[N] plus an encoded index.
- All state stays in mem_arbiter: ptr, lock_cnt, command register, read tag and valid.

## Test plan
- **Reset.** Assert rst with all req high. Required: gnt=0, mem_en=0, rvalid=0. After release, the first gnt is port 0.
- **Single read.** Port 1 reads addr 0x010, with RAM holding 0xDEADBEEF there. Required: gnt[1] in cycle t, mem_en/mem_addr=0x010 in t+1, rvalid[1]=1 with rdata=0xDEADBEEF in t+2.
- **Round-robin.** All three ports hold reads for 6 cycles, lock=0. Required: grants in order 0,1,2,0,1,2; rvalid order matches, 2 cycles later.
- **Lock cap.** Port 2 holds req+lock, ports 0 and 1 request, MAX_LOCK=8. Required: port 2 gets exactly 8 consecutive grants, then port 0, then port 1.
- **Write then read.** Port 0 writes 0x12345678 to 0xFFF at t; port 0 reads 0xFFF at t+1. Required: rvalid[0] at t+3 with rdata=0x12345678; no rvalid for the write.
- **Reset mid-read.** Read is handshaken at t; rst is asserted in t+1. Required: no rvalid in t+2, and ptr returns to 0.
